// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler sequencer: opcodes, control words, FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package nibbler_pkg;

    localparam int CW_W    = 13;
    localparam int MEM_BIT = 5;   // control-word bit that marks a data-memory access

    // Base instruction encodings (low nibble of the opcode)
    localparam logic [3:0] OP_JC    = 4'h0;
    localparam logic [3:0] OP_JNC   = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_CMPM  = 4'h3;
    localparam logic [3:0] OP_LIT   = 4'h4;
    localparam logic [3:0] OP_IN    = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_OUT   = 4'hD;
    localparam logic [3:0] OP_NANDI = 4'hE;
    localparam logic [3:0] OP_NANDM = 4'hF;

    // Control words; CW_FETCH doubles as "PC increment only"
    localparam logic [CW_W-1:0] CW_FETCH     = 13'b1000000001000;
    localparam logic [CW_W-1:0] CW_JMP_TAKEN = 13'b0100000001000;
    localparam logic [CW_W-1:0] CW_CMPI      = 13'b0001001000010;
    localparam logic [CW_W-1:0] CW_CMPM      = 13'b1001001100000;
    localparam logic [CW_W-1:0] CW_LIT       = 13'b0011010000010;
    localparam logic [CW_W-1:0] CW_IN        = 13'b0011010000100;
    localparam logic [CW_W-1:0] CW_LD        = 13'b1011010100000;
    localparam logic [CW_W-1:0] CW_ST        = 13'b1000000111000;
    localparam logic [CW_W-1:0] CW_ADDI      = 13'b0011011000010;
    localparam logic [CW_W-1:0] CW_ADDM      = 13'b1011011100000;
    localparam logic [CW_W-1:0] CW_OUT       = 13'b0000000001001;
    localparam logic [CW_W-1:0] CW_NANDI     = 13'b0011100000010;
    localparam logic [CW_W-1:0] CW_NANDM     = 13'b1011100100000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/nibbler_sequencer_if.sv
// Bus between the sequencer and the program bus / flag register / datapath.
// Latency: none (wires only).
// Backpressure: mem_ready is the only throttle; enable pauses the whole sequencer.
interface nibbler_sequencer_if #(
    parameter int OP_W   = 4,
    parameter int CTRL_W = 13,
    parameter int CNT_W  = 16
);
    logic              enable;
    logic [OP_W-1:0]   opcode;
    logic              c_flag;
    logic              z_flag;
    logic              mem_ready;
    logic              phase;
    logic [CTRL_W-1:0] ctrl;
    logic              ctrl_commit;
    logic              retire;
    logic              illegal_op;
    logic [CNT_W-1:0]  retired_cnt;

    // Environment side: drives instruction/flags, consumes control
    modport master (
        output enable, opcode, c_flag, z_flag, mem_ready,
        input  phase, ctrl, ctrl_commit, retire, illegal_op, retired_cnt
    );

    // Sequencer side
    modport slave (
        input  enable, opcode, c_flag, z_flag, mem_ready,
        output phase, ctrl, ctrl_commit, retire, illegal_op, retired_cnt
    );
endinterface

// File: rtl/nibbler_ctrl_rom.sv
// Combinational decode of (ir, C, Z) into the 13-bit EXEC control word plus illegal flag.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; flags are consumed live.
module nibbler_ctrl_rom import nibbler_pkg::*; #(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] ir_i,
    input  logic            c_flag_i,
    input  logic            z_flag_i,
    output logic [CW_W-1:0] word_o,
    output logic            illegal_o
);

    logic [CW_W-1:0] base_word;

    // Any opcode bit above the base nibble makes the instruction illegal
    generate
        if (OP_W > 4) begin : g_wide
            assign illegal_o = |ir_i[OP_W-1:4];
        end else begin : g_narrow
            assign illegal_o = 1'b0;
        end
    endgenerate

    // Base nibble decode; conditional jumps look at the live flags
    always_comb begin
        base_word = CW_FETCH;
        case (ir_i[3:0])
            OP_JC:    base_word = c_flag_i ? CW_JMP_TAKEN : CW_FETCH;
            OP_JNC:   base_word = c_flag_i ? CW_FETCH : CW_JMP_TAKEN;
            OP_CMPI:  base_word = CW_CMPI;
            OP_CMPM:  base_word = CW_CMPM;
            OP_LIT:   base_word = CW_LIT;
            OP_IN:    base_word = CW_IN;
            OP_LD:    base_word = CW_LD;
            OP_ST:    base_word = CW_ST;
            OP_JZ:    base_word = z_flag_i ? CW_JMP_TAKEN : CW_FETCH;
            OP_JNZ:   base_word = z_flag_i ? CW_FETCH : CW_JMP_TAKEN;
            OP_ADDI:  base_word = CW_ADDI;
            OP_ADDM:  base_word = CW_ADDM;
            OP_JMP:   base_word = CW_JMP_TAKEN;
            OP_OUT:   base_word = CW_OUT;
            OP_NANDI: base_word = CW_NANDI;
            OP_NANDM: base_word = CW_NANDM;
            default:  base_word = CW_FETCH;
        endcase
    end

    // Illegal opcodes degrade to a plain PC increment
    assign word_o = illegal_o ? CW_FETCH : base_word;

endmodule

// File: rtl/nibbler_sequencer.sv
// Fetch/execute sequencer: latches opcode, emits phase control word, counts retirements.
// Latency: 2 cycles per instruction (FETCH, EXEC) plus one per WAIT cycle; outputs combinational.
// Backpressure: enable=0 freezes everything; with NIBBLER_WAIT_EN, mem_ready=0 stalls memory ops.
module nibbler_sequencer import nibbler_pkg::*; #(
    parameter int OP_W   = 4,
    parameter int CTRL_W = 13,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    nibbler_sequencer_if.slave bus
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [CW_W-1:0]   rom_word;
    logic              rom_illegal;
    logic              in_exec;
    logic              stall;
    logic              retire_w;
    logic [CTRL_W-1:0] ctrl_w;

    nibbler_ctrl_rom #(.OP_W(OP_W)) u_rom (
        .ir_i      (ir_q),
        .c_flag_i  (bus.c_flag),
        .z_flag_i  (bus.z_flag),
        .word_o    (rom_word),
        .illegal_o (rom_illegal)
    );

    assign in_exec = (state_q == ST_EXEC) || (state_q == ST_WAIT);

`ifdef NIBBLER_WAIT_EN
    // Memory instructions hold off until the data memory reports ready
    assign stall = in_exec && rom_word[MEM_BIT] && !bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign stall            = 1'b0;
`endif

    assign retire_w = bus.enable && in_exec && !stall;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable=0 holds the current state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (bus.enable) state_d = ST_EXEC;
`ifdef NIBBLER_WAIT_EN
            ST_EXEC:  if (bus.enable) state_d = stall ? ST_WAIT : ST_FETCH;
            ST_WAIT:  if (bus.enable && !stall) state_d = ST_FETCH;
`else
            ST_EXEC:  if (bus.enable) state_d = ST_FETCH;
`endif
            default:  state_d = ST_FETCH;
        endcase
    end

    // Outputs: pause blanks the control word; stalled EXEC/WAIT shows the word uncommitted
    always_comb begin
        ctrl_w = '0;
        if (bus.enable) begin
            ctrl_w[CW_W-1:0] = (state_q == ST_FETCH) ? CW_FETCH : rom_word;
        end
        bus.ctrl        = ctrl_w;
        bus.phase       = (state_q != ST_FETCH);
        bus.ctrl_commit = bus.enable && ((state_q == ST_FETCH) || (in_exec && !stall));
        bus.retire      = retire_w;
        bus.illegal_op  = retire_w && rom_illegal;
        bus.retired_cnt = cnt_q;
    end

    // Instruction latch and saturating retirement counter next-state
    always_comb begin
        ir_d  = ir_q;
        cnt_d = cnt_q;
        if (bus.enable && (state_q == ST_FETCH)) begin
            ir_d = bus.opcode;
        end
        if (retire_w && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Instruction and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q  <= '0;
            cnt_q <= '0;
        end else begin
            ir_q  <= ir_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Directed bench for nibbler_sequencer: default instance plus OP_W=6/CNT_W=2 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_nibbler_sequencer;
    import nibbler_pkg::*;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_chk;
    int   n_fail;

    nibbler_sequencer_if #(.OP_W(4), .CTRL_W(13), .CNT_W(16)) if_a ();
    nibbler_sequencer_if #(.OP_W(6), .CTRL_W(13), .CNT_W(2))  if_b ();

    nibbler_sequencer #(.OP_W(4), .CTRL_W(13), .CNT_W(16)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a.slave)
    );

    nibbler_sequencer #(.OP_W(6), .CTRL_W(13), .CNT_W(2)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Run one instruction on instance A starting from FETCH; check its EXEC word and retire
    task automatic run_a(input logic [3:0] op, input logic c, input logic z, input logic mr,
                         input logic [12:0] exp_word, input string tag);
        if_a.opcode    = op;
        if_a.enable    = 1'b1;
        if_a.mem_ready = mr;
        #1;
        chk({tag, "_fetch"}, 32'(if_a.ctrl), 32'(CW_FETCH));
        tick();
        if_a.opcode = ~op;
        if_a.c_flag = c;
        if_a.z_flag = z;
        #1;
        chk({tag, "_ctrl"},   32'(if_a.ctrl),   32'(exp_word));
        chk({tag, "_retire"}, 32'(if_a.retire), 32'd1);
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.enable = 1'b1; if_a.opcode = 4'h4; if_a.c_flag = 1'b0; if_a.z_flag = 1'b0; if_a.mem_ready = 1'b1;
        if_b.enable = 1'b1; if_b.opcode = '0;   if_b.c_flag = 1'b0; if_b.z_flag = 1'b0; if_b.mem_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_phase",   32'(if_a.phase),       32'd0);
        chk("rst_ctrl",    32'(if_a.ctrl),        32'(CW_FETCH));
        chk("rst_commit",  32'(if_a.ctrl_commit), 32'd1);
        chk("rst_retire",  32'(if_a.retire),      32'd0);
        chk("rst_illegal", 32'(if_a.illegal_op),  32'd0);
        chk("rst_cnt",     32'(if_a.retired_cnt), 32'd0);
        if_a.enable = 1'b0;
        #1;
        chk("rst_commit_en0", 32'(if_a.ctrl_commit), 32'd0);
        chk("rst_ctrl_en0",   32'(if_a.ctrl),        32'd0);
        if_a.enable = 1'b1;

        // First instruction: LIT
        rst_a = 1'b0;
        tick();
        chk("lit_phase",  32'(if_a.phase),       32'd1);
        chk("lit_ctrl",   32'(if_a.ctrl),        32'(CW_LIT));
        chk("lit_retire", 32'(if_a.retire),      32'd1);
        chk("lit_commit", 32'(if_a.ctrl_commit), 32'd1);
        if_a.opcode = 4'hF;
        #1;
        chk("lit_ir_latched", 32'(if_a.ctrl), 32'(CW_LIT));
        tick();
        chk("lit_cnt",        32'(if_a.retired_cnt), 32'd1);
        chk("lit_back_fetch", 32'(if_a.phase),       32'd0);
        chk("fetch_retire",   32'(if_a.retire),      32'd0);

        // Instruction table, flags applied live in EXEC
        run_a(4'h0, 1'b1, 1'b0, 1'b1, CW_JMP_TAKEN, "jc_taken");
        run_a(4'h0, 1'b0, 1'b0, 1'b1, CW_FETCH,     "jc_not");
        run_a(4'h9, 1'b0, 1'b0, 1'b1, CW_JMP_TAKEN, "jnz_taken");
        run_a(4'h9, 1'b0, 1'b1, 1'b1, CW_FETCH,     "jnz_not");
        run_a(4'h8, 1'b0, 1'b1, 1'b1, CW_JMP_TAKEN, "jz_taken");
        run_a(4'h1, 1'b1, 1'b0, 1'b1, CW_FETCH,     "jnc_not");
        run_a(4'h7, 1'b0, 1'b0, 1'b1, CW_ST,        "st");
        run_a(4'hA, 1'b0, 1'b0, 1'b0, CW_ADDI,      "addi_mr0");
        run_a(4'hD, 1'b0, 1'b0, 1'b1, CW_OUT,       "out");
        run_a(4'hC, 1'b0, 1'b0, 1'b1, CW_JMP_TAKEN, "jmp");
        chk("table_cnt", 32'(if_a.retired_cnt), 32'd11);

        // Pause for two cycles in EXEC
        if_a.opcode = 4'hE;
        tick();
        if_a.enable = 1'b0;
        #1;
        chk("pause_ctrl",   32'(if_a.ctrl),        32'd0);
        chk("pause_commit", 32'(if_a.ctrl_commit), 32'd0);
        chk("pause_retire", 32'(if_a.retire),      32'd0);
        tick();
        chk("pause_phase", 32'(if_a.phase),       32'd1);
        tick();
        chk("pause_cnt",   32'(if_a.retired_cnt), 32'd11);
        if_a.enable = 1'b1;
        #1;
        chk("resume_ctrl",   32'(if_a.ctrl),   32'(CW_NANDI));
        chk("resume_retire", 32'(if_a.retire), 32'd1);
        tick();
        chk("resume_cnt", 32'(if_a.retired_cnt), 32'd12);

        // Memory instruction with mem_ready low
        if_a.opcode    = 4'h6;
        if_a.mem_ready = 1'b0;
        tick();
`ifdef NIBBLER_WAIT_EN
        for (int i = 0; i < 3; i++) begin
            chk("ld_wait_phase",  32'(if_a.phase),       32'd1);
            chk("ld_wait_commit", 32'(if_a.ctrl_commit), 32'd0);
            chk("ld_wait_retire", 32'(if_a.retire),      32'd0);
            chk("ld_wait_ctrl",   32'(if_a.ctrl),        32'(CW_LD));
            tick();
        end
        if_a.mem_ready = 1'b1;
        #1;
        chk("ld_done_phase",  32'(if_a.phase),       32'd1);
        chk("ld_done_commit", 32'(if_a.ctrl_commit), 32'd1);
        chk("ld_done_retire", 32'(if_a.retire),      32'd1);
`else
        chk("ld_nowait_commit", 32'(if_a.ctrl_commit), 32'd1);
        chk("ld_nowait_retire", 32'(if_a.retire),      32'd1);
        chk("ld_nowait_ctrl",   32'(if_a.ctrl),        32'(CW_LD));
`endif
        tick();
        chk("ld_cnt",   32'(if_a.retired_cnt), 32'd13);
        chk("ld_phase", 32'(if_a.phase),       32'd0);

        // Reset mid-instruction
        if_a.opcode    = 4'h6;
        if_a.mem_ready = 1'b0;
        tick();
`ifdef NIBBLER_WAIT_EN
        tick();
        chk("wait_before_rst", 32'(if_a.phase), 32'd1);
        rst_a = 1'b1;
        #1;
        chk("rst_in_wait_retire", 32'(if_a.retire), 32'd0);
`else
        rst_a = 1'b1;
`endif
        tick();
        rst_a = 1'b0;
        #1;
        chk("midrst_phase",  32'(if_a.phase),       32'd0);
        chk("midrst_cnt",    32'(if_a.retired_cnt), 32'd0);
        chk("midrst_retire", 32'(if_a.retire),      32'd0);

        // Wide-opcode instance: illegal detection and 2-bit saturation
        rst_b = 1'b0;
        if_b.opcode = 6'b010101;
        tick();
        if_b.opcode = 6'b000000;
        #1;
        chk("illegal_pulse",  32'(if_b.illegal_op), 32'd1);
        chk("illegal_ctrl",   32'(if_b.ctrl),       32'(CW_FETCH));
        chk("illegal_retire", 32'(if_b.retire),     32'd1);
        tick();
        chk("illegal_gone", 32'(if_b.illegal_op), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if_b.opcode = 6'b000100;
            tick();
            chk("legal_no_illegal", 32'(if_b.illegal_op), 32'd0);
            tick();
            if (i == 1) chk("sat_reach", 32'(if_b.retired_cnt), 32'd3);
        end
        chk("sat_hold", 32'(if_b.retired_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nibbler_sequencer.md
# nibbler_sequencer

Parametrised control sequencer for the Nibbler datapath, successor to the purely combinational phase/opcode decoder. It owns the fetch/execute phase state machine, latches the instruction opcode, and emits the control word for the current phase. It adds optional memory wait-state stalling, a run/pause enable, illegal-opcode detection and a retired-instruction counter. It sits between the program ROM/instruction bus and the datapath (PC, accumulator, ALU, flags, data RAM, output port).

## Interface
- OP_W, 4: opcode width; must be ≥ 4. Bits [3:0] select the base instruction; any set bit above bit 3 marks the opcode illegal.
- CTRL_W, 13: control-word width; must be ≥ 13. Bits above 12 are always 0.
- CNT_W, 16: retired-instruction counter width.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run enable; 0 pauses the sequencer.
- opcode  in  OP_W  instruction opcode from the program bus; sampled in FETCH.
- c_flag  in  1  carry flag from the flag register; used live in EXEC.
- z_flag  in  1  zero flag from the flag register; used live in EXEC.
- mem_ready  in  1  data-memory ready; used only with NIBBLER_WAIT_EN.
- phase  out  1  0 in FETCH, 1 in EXEC and WAIT.
- ctrl  out  CTRL_W  control word.
- ctrl_commit  out  1  1 when the datapath must act on ctrl this cycle.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal_op  out  1  one-cycle pulse on an EXEC commit of an illegal opcode.
- retired_cnt  out  CNT_W  saturating count of retired instructions.

## Operation
- States: FETCH, EXEC, WAIT. WAIT is reachable only with NIBBLER_WAIT_EN.
- FETCH:
  - ctrl = 1000000001000.
  - If enable=1: ir <= opcode, go to EXEC.
- EXEC ctrl by ir[3:0]:
  - 0000 JC: C=1 gives 0100000001000, else 1000000001000.
  - 0001 JNC: the JC words, swapped.
  - 0010 CMPI: 0001001000010.
  - 0011 CMPM: 1001001100000.
  - 0100 LIT: 0011010000010.
  - 0101 IN: 0011010000100.
  - 0110 LD: 1011010100000.
  - 0111 ST: 1000000111000.
  - 1000 JZ: Z=1 gives 0100000001000, else 1000000001000.
  - 1001 JNZ: the JZ words, swapped.
  - 1010 ADDI: 0011011000010.
  - 1011 ADDM: 1011011100000.
  - 1100 JMP: 0100000001000.
  - 1101 OUT: 0000000001001.
  - 1110 NANDI: 0011100000010.
  - 1111 NANDM: 1011100100000.
- Illegal ir (any bit above 3 set): ctrl = 1000000001000 (PC increment only), illegal_op pulses on commit.
- A memory instruction is any EXEC word with ctrl bit 5 = 1.
- EXEC transitions:
  - enable=1 and no stall: commit, retire, go to FETCH.
  - Stall (NIBBLER_WAIT_EN, memory instruction, mem_ready=0): go to WAIT, no commit.
- WAIT:
  - ctrl holds the EXEC word for ir, re-evaluated with live flags. ctrl_commit=0.
  - mem_ready=1 and enable=1: commit, retire, go to FETCH.
- Pause: enable=0 forces ctrl=0 and ctrl_commit=0. State, ir and counter hold.
- ctrl_commit = enable & (state==FETCH | (state∈{EXEC,WAIT} & no stall)).
- retired_cnt increments on retire and saturates at all ones.

## Timing
- Reset values: state FETCH, ir=0, retired_cnt=0, retire=0, illegal_op=0, phase=0, ctrl=1000000001000, ctrl_commit=enable.
- ctrl, ctrl_commit, retire and illegal_op are combinational from state, ir, flags, enable and mem_ready. No added latency.
- Minimum instruction time: 2 cycles (FETCH, EXEC). Each cycle spent in WAIT adds one.
- retired_cnt updates on the edge that closes the retiring cycle.
- Reset in any state, including WAIT, returns to FETCH on the next edge and discards ir.
- mem_ready is ignored outside EXEC/WAIT and for non-memory instructions.
- When enable and mem_ready rise in the same cycle in WAIT, the instruction commits.

## Configuration
- NIBBLER_WAIT_EN defined: memory instructions stall on mem_ready=0 through the WAIT state.
- NIBBLER_WAIT_EN undefined: the WAIT state and mem_ready logic are not compiled. mem_ready is ignored and EXEC always completes in one cycle.

## Structure
- Shared package nibbler_pkg holds:
  - opcode constants;
  - the 13-bit control-word constants (CW_FETCH, CW_JMP_TAKEN, CW_CMPI, ...);
  - the state enum;
  - the memory-bit index (5).
- Sub-module nibbler_ctrl_rom: combinational map from (ir, c_flag, z_flag) to the 13-bit word plus an illegal flag. The sequencer owns the FSM, ir, pause/stall muxing and the counter.

## Test plan
- Reset, then opcode=0100 with enable=1 → FETCH word 1000000001000, then EXEC word 0011010000010, retire=1, retired_cnt=1.
- JC with c_flag=1 → EXEC 0100000001000. JC with c_flag=0 → 1000000001000. JNZ with z_flag=0 → 0100000001000.
- NIBBLER_WAIT_EN, LD (0110), mem_ready low 3 cycles → phase=1 for 4 cycles, ctrl_commit=0 for 3 cycles, single retire on the 4th.
- enable=0 during EXEC for 2 cycles → ctrl=0, state, ir and counter hold; resumes with the same EXEC word.
- OP_W=6, opcode=010101 → illegal_op pulse, ctrl 1000000001000. With CNT_W=2, 5 instructions → retired_cnt stays at 3.
- reset asserted in WAIT → next cycle FETCH, retired_cnt=0, no retire pulse.
